// File: rtl/shift_reg_sipo_pkg.sv
// Shared constants and helpers for the shift_reg_sipo deserialiser slice.
package shift_reg_sipo_pkg;

  // Default number of stages (and width of the parallel word).
  localparam int unsigned SIPO_DEFAULT_WIDTH = 4;

  // Default reset image; wide enough for the largest legal WIDTH (64).
  localparam logic [63:0] SIPO_DEFAULT_RESET_VALUE = '0;

  // Width of the modulo-WIDTH bit counter, never narrower than one bit.
  function automatic int unsigned sipo_cnt_width(input int unsigned width);
    int unsigned w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/shift_reg_sipo_stage.sv
// sipo_stage: one D flop with synchronous active-low reset.
module sipo_stage #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  // Load the reset bit on a low reset_n edge, otherwise capture d.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= RESET_BIT;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/shift_reg_sipo.sv
// shift_reg_sipo: serial-in, parallel-out shift register.
// New bits enter q[WIDTH-1] and move one place toward q[0] per clock.
// Optional feature macro: SHIFT_REG_SIPO_WORD_VALID_EN adds a registered
// word_valid pulse marking each complete fresh word.
module shift_reg_sipo
  import shift_reg_sipo_pkg::*;
#(
  parameter int unsigned       WIDTH       = SIPO_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VALUE = SIPO_DEFAULT_RESET_VALUE[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sdi,
`ifdef SHIFT_REG_SIPO_WORD_VALID_EN
  output logic             word_valid,
`endif
  output logic [WIDTH-1:0] q
);

  // Each stage is fed from its left neighbour; the MSB stage takes sdi.
  logic [WIDTH-1:0] stage_d;
  assign stage_d = {sdi, q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    sipo_stage #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (stage_d[i]),
      .q       (q[i])
    );
  end

`ifdef SHIFT_REG_SIPO_WORD_VALID_EN
  localparam int unsigned CNT_W = sipo_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] bit_cnt;

  // Count shifts modulo WIDTH; flag the shift that completes a word so the
  // pulse lines up with the cycle q first holds that word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= (bit_cnt == CNT_LAST);
      bit_cnt    <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_reg_sipo.sv
// Directed + random scoreboard bench for shift_reg_sipo (WIDTH=4).
// Checks word_valid too when SHIFT_REG_SIPO_WORD_VALID_EN is defined.
module tb_shift_reg_sipo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sdi;
  logic [3:0] q;
`ifdef SHIFT_REG_SIPO_WORD_VALID_EN
  logic       word_valid;
`endif

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [3:0] exp_q_fifo [$];
  logic       exp_wv_fifo [$];
  logic [3:0] model_q   = '0;
  int unsigned model_cnt = 0;

  always #5 clk = ~clk;

  shift_reg_sipo #(
    .WIDTH       (4),
    .RESET_VALUE (4'b0000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sdi        (sdi),
`ifdef SHIFT_REG_SIPO_WORD_VALID_EN
    .word_valid (word_valid),
`endif
    .q          (q)
  );

  // Drive one edge, push the expected q (and word_valid), then compare.
  task automatic step(input string tag, input logic rn, input logic d,
                      input logic [3:0] e);
    logic [3:0] eq;
    logic       ewv;
    @(negedge clk);
    reset_n = rn;
    sdi     = d;
    if (!rn) begin
      ewv       = 1'b0;
      model_cnt = 0;
    end else begin
      ewv       = (model_cnt == 3);
      model_cnt = (model_cnt + 1) % 4;
    end
    exp_q_fifo.push_back(e);
    exp_wv_fifo.push_back(ewv);
    model_q = e;
    @(posedge clk);
    #1;
    eq  = exp_q_fifo.pop_front();
    ewv = exp_wv_fifo.pop_front();
    vectors++;
    assert (q === eq) else begin
      miscompares++;
      $error("FAIL %s q=%b expected %b", tag, q, eq);
    end
`ifdef SHIFT_REG_SIPO_WORD_VALID_EN
    vectors++;
    assert (word_valid === ewv) else begin
      miscompares++;
      $error("FAIL %s word_valid=%b expected %b", tag, word_valid, ewv);
    end
`endif
  endtask

  initial begin
    logic d;
    logic rn;
    reset_n = 1'b0;
    sdi     = 1'b0;

    // Reset, and reset holding against sdi=1.
    step("rst0", 0, 0, 4'b0000);
    step("rst1", 0, 0, 4'b0000);
    step("rst_sdi1", 0, 1, 4'b0000);

    // Single pulse walks MSB to LSB and drops out.
    step("pulse1", 1, 1, 4'b1000);
    step("pulse2", 1, 0, 4'b0100);
    step("pulse3", 1, 0, 4'b0010);
    step("pulse4", 1, 0, 4'b0001);
    step("pulse5", 1, 0, 4'b0000);

    // Two-clock pulse.
    step("dbl1", 1, 1, 4'b1000);
    step("dbl2", 1, 1, 4'b1100);
    step("dbl3", 1, 0, 4'b0110);
    step("dbl4", 1, 0, 4'b0011);
    step("dbl5", 1, 0, 4'b0001);
    step("dbl6", 1, 0, 4'b0000);

    // Steady ones fill and hold, then drain.
    step("ones1", 1, 1, 4'b1000);
    step("ones2", 1, 1, 4'b1100);
    step("ones3", 1, 1, 4'b1110);
    step("ones4", 1, 1, 4'b1111);
    step("ones5", 1, 1, 4'b1111);
    step("ones6", 1, 1, 4'b1111);
    step("drain1", 1, 0, 4'b0111);
    step("drain2", 1, 0, 4'b0011);
    step("drain3", 1, 0, 4'b0001);
    step("drain4", 1, 0, 4'b0000);

    // Mid-stream reset clears with sdi=1, release shifts that edge's sdi.
    step("fill1", 1, 1, 4'b1000);
    step("fill2", 1, 1, 4'b1100);
    step("fill3", 1, 1, 4'b1110);
    step("fill4", 1, 1, 4'b1111);
    step("midrst", 0, 1, 4'b0000);
    step("release", 1, 1, 4'b1000);

    // Word stream 1,0,1,1,0,0,1,0 from reset.
    step("wrst", 0, 0, 4'b0000);
    step("w1", 1, 1, 4'b1000);
    step("w2", 1, 0, 4'b0100);
    step("w3", 1, 1, 4'b1010);
    step("w4", 1, 1, 4'b1101);
    step("w5", 1, 0, 4'b0110);
    step("w6", 1, 0, 4'b0011);
    step("w7", 1, 1, 4'b1001);
    step("w8", 1, 0, 4'b0100);

    // Random stream with occasional resets.
    for (int i = 0; i < 60; i++) begin
      d  = 1'($urandom_range(0, 1));
      rn = ($urandom_range(0, 9) != 0);
      step("rand", rn, d, rn ? {d, model_q[3:1]} : 4'b0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
